// File: rtl/reg_file_sb.sv
// Register file with NRD combinational read ports, one write port and a pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle writeback to the read ports.
module reg_file_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NRD*AW-1:0] rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]    rs_busy,
  output logic              hazard,
  input  logic [NRD-1:0]    rs_use,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_rd,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_rd,
  input  logic [XLEN-1:0]   wb_data
);

  logic [XLEN-1:0]  rf_reg [NREGS];
  logic [NREGS-1:0] pend_reg;
  logic [NREGS-1:0] pend_next;
  logic             wb_fire;
  logic             iss_fire;

  assign wb_fire  = en && wb_en  && (wb_rd  != '0);
  assign iss_fire = en && iss_en && (iss_rd != '0);

  // Clear before set, so a producer issued in the same cycle as the old one retires stays pending.
  always_comb begin
    pend_next = pend_reg;
    if (wb_fire) begin
      pend_next[wb_rd] = 1'b0;
    end
    if (iss_fire) begin
      pend_next[iss_rd] = 1'b1;
    end
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_reg[i] <= '0;
      end
      pend_reg <= '0;
    end else if (en) begin
      if (wb_fire) begin
        rf_reg[wb_rd] <= wb_data;
      end
      pend_reg <= pend_next;
    end
  end

  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0] addr;
      logic          fwd_hit;

      assign addr = rs_addr[gi*AW +: AW];

`ifdef REGFILE_BYPASS_EN
      assign fwd_hit = wb_fire && (addr == wb_rd);
`else
      assign fwd_hit = 1'b0;
`endif

      // x0 is forced to zero on the read side as well, independent of array contents.
      always_comb begin
        rs_data[gi*XLEN +: XLEN] = rf_reg[addr];
        rs_busy[gi]              = pend_reg[addr];
        if (addr == '0) begin
          rs_data[gi*XLEN +: XLEN] = '0;
          rs_busy[gi]              = 1'b0;
        end else if (fwd_hit) begin
          rs_data[gi*XLEN +: XLEN] = wb_data;
          rs_busy[gi]              = 1'b0;
        end
      end
    end
  endgenerate

  assign hazard = |(rs_busy & rs_use);

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus randomized traffic against an array model.
module tb_reg_file_sb;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NRD = 2;
  localparam int AW = 5;

  logic              clk = 1'b0;
  logic              rst, en, iss_en, wb_en;
  logic [NRD*AW-1:0] rs_addr;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]    rs_busy, rs_use;
  logic              hazard;
  logic [AW-1:0]     iss_rd, wb_rd;
  logic [XLEN-1:0]   wb_data;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] m_rf [NREGS];
  bit              m_pend [NREGS];

  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk(clk), .rst(rst), .en(en), .rs_addr(rs_addr), .rs_data(rs_data),
    .rs_busy(rs_busy), .hazard(hazard), .rs_use(rs_use), .iss_en(iss_en),
    .iss_rd(iss_rd), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  // Expected read value for address a given the current inputs.
  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (en && wb_en && wb_rd != 0 && a == wb_rd) return wb_data;
`endif
    return m_rf[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (en && wb_en && wb_rd != 0 && a == wb_rd) return 1'b0;
`endif
    return m_pend[a];
  endfunction

  // Advance the model by one edge from the current inputs, then clock the DUT.
  task automatic tick();
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        m_rf[i] = '0;
        m_pend[i] = 1'b0;
      end
    end else if (en) begin
      if (wb_en && wb_rd != 0) begin
        m_rf[wb_rd] = wb_data;
        m_pend[wb_rd] = 1'b0;
      end
      if (iss_en && iss_rd != 0) m_pend[iss_rd] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; en = 1; iss_en = 0; wb_en = 0; iss_rd = 0; wb_rd = 0; wb_data = 0;
    rs_use = 0;
  endtask

  task automatic set_addr(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rs_addr = {a1, a0};
    #1;
  endtask

  task automatic write_reg(input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
    wb_en = 1; wb_rd = rd; wb_data = d;
    tick();
    wb_en = 0;
  endtask

  task automatic test_reset();
    for (int i = 1; i < NREGS; i++) begin
      wb_en = 1; wb_rd = AW'(i); wb_data = $urandom;
      iss_en = 1; iss_rd = AW'(NREGS - i);
      tick();
    end
    // Reset must win over concurrent write and issue.
    rst = 1; wb_en = 1; wb_rd = 5'd3; wb_data = 32'hFFFF_FFFF; iss_en = 1; iss_rd = 5'd3;
    tick();
    idle();
    for (int a = 0; a < NREGS; a++) begin
      rs_use = 2'b11;
      set_addr(AW'(a), AW'(NREGS - 1 - a));
      checks++;
      if (rs_data[31:0] !== 32'h0 || rs_data[63:32] !== 32'h0) begin
        errors++;
        $display("FAIL reset_data addr=%0d: got %h required 0", a, rs_data);
      end
      checks++;
      if (rs_busy !== 2'b00 || hazard !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy addr=%0d: got busy=%b hazard=%b required 00/0", a, rs_busy, hazard);
      end
    end
  endtask

  task automatic test_write_read();
    write_reg(5'd5, 32'hDEADBEEF);
    set_addr(5'd5, 5'd5);
    checks++;
    if (rs_data[31:0] !== 32'hDEADBEEF || rs_data[63:32] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_read_x5: got %h required DEADBEEF on both ports", rs_data);
    end
    write_reg(5'd0, 32'h1234);
    set_addr(5'd0, 5'd5);
    checks++;
    if (rs_data[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL x0_write: got %h required 0", rs_data[31:0]);
    end
  endtask

  task automatic test_scoreboard();
    iss_en = 1; iss_rd = 5'd7;
    tick();
    iss_en = 0;
    rs_use = 2'b10;
    set_addr(5'd0, 5'd7);
    checks++;
    if (rs_busy[1] !== 1'b1 || hazard !== 1'b1) begin
      errors++;
      $display("FAIL sb_busy: got busy1=%b hazard=%b required 1/1", rs_busy[1], hazard);
    end
    rs_use = 2'b00;
    #1;
    checks++;
    if (hazard !== 1'b0) begin
      errors++;
      $display("FAIL sb_nouse: got hazard=%b required 0", hazard);
    end
    rs_use = 2'b01;
    #1;
    checks++;
    if (hazard !== 1'b0) begin
      errors++;
      $display("FAIL sb_wrong_use: got hazard=%b required 0", hazard);
    end
    rs_use = 2'b10;
    write_reg(5'd7, 32'h7777);
    #1;
    checks++;
    if (rs_busy[1] !== 1'b0 || hazard !== 1'b0 || rs_data[63:32] !== 32'h7777) begin
      errors++;
      $display("FAIL sb_clear: got busy1=%b hazard=%b data=%h required 0/0/00007777", rs_busy[1], hazard, rs_data[63:32]);
    end
    rs_use = 0;
  endtask

  task automatic test_simultaneous();
    iss_en = 1; iss_rd = 5'd9; wb_en = 1; wb_rd = 5'd9; wb_data = 32'h55;
    tick();
    iss_en = 0; wb_en = 0;
    set_addr(5'd9, 5'd0);
    checks++;
    if (rs_data[31:0] !== 32'h55 || rs_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL simul_iss_wb: got data=%h busy=%b required 00000055/1", rs_data[31:0], rs_busy[0]);
    end
    write_reg(5'd9, 32'h56);
    iss_en = 1; iss_rd = 5'd0;
    tick();
    iss_en = 0;
    set_addr(5'd0, 5'd0);
    checks++;
    if (rs_busy !== 2'b00) begin
      errors++;
      $display("FAIL iss_x0: got busy=%b required 00", rs_busy);
    end
  endtask

  task automatic test_enable();
    write_reg(5'd3, 32'h11);
    en = 0; wb_en = 1; wb_rd = 5'd3; wb_data = 32'hFF; iss_en = 1; iss_rd = 5'd4;
    tick();
    wb_en = 0; iss_en = 0;
    set_addr(5'd3, 5'd4);
    checks++;
    if (rs_data[31:0] !== 32'h11 || rs_busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL en_freeze: got x3=%h busy4=%b required 00000011/0", rs_data[31:0], rs_busy[1]);
    end
    en = 1; wb_en = 1; wb_rd = 5'd3; wb_data = 32'hFF; iss_en = 1; iss_rd = 5'd4;
    tick();
    wb_en = 0; iss_en = 0;
    #1;
    checks++;
    if (rs_data[31:0] !== 32'hFF || rs_busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL en_resume: got x3=%h busy4=%b required 000000FF/1", rs_data[31:0], rs_busy[1]);
    end
    write_reg(5'd4, 32'h44);
  endtask

  task automatic test_bypass();
    logic [XLEN-1:0] req_data;
    logic            req_busy;
    write_reg(5'd6, 32'h33);
    iss_en = 1; iss_rd = 5'd6;
    tick();
    iss_en = 0;
    wb_en = 1; wb_rd = 5'd6; wb_data = 32'hA5;
    set_addr(5'd6, 5'd1);
`ifdef REGFILE_BYPASS_EN
    req_data = 32'hA5; req_busy = 1'b0;
`else
    req_data = 32'h33; req_busy = 1'b1;
`endif
    checks++;
    if (rs_data[31:0] !== req_data || rs_busy[0] !== req_busy) begin
      errors++;
      $display("FAIL bypass_same_cycle: got data=%h busy=%b required %h/%b", rs_data[31:0], rs_busy[0], req_data, req_busy);
    end
    tick();
    wb_en = 0;
    #1;
    checks++;
    if (rs_data[31:0] !== 32'hA5 || rs_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL bypass_after: got data=%h busy=%b required 000000A5/0", rs_data[31:0], rs_busy[0]);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int n = 0; n < 400; n++) begin
      rst     = ($urandom_range(0, 60) == 0);
      en      = ($urandom_range(0, 9) != 0);
      wb_en   = $urandom_range(0, 1);
      wb_rd   = AW'($urandom_range(0, 7));
      wb_data = $urandom;
      iss_en  = $urandom_range(0, 1);
      iss_rd  = AW'($urandom_range(0, 7));
      rs_use  = NRD'($urandom_range(0, 3));
      set_addr(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      for (int p = 0; p < NRD; p++) begin
        a = rs_addr[p*AW +: AW];
        checks++;
        if (rs_data[p*XLEN +: XLEN] !== exp_data(a) || rs_busy[p] !== exp_busy(a)) begin
          errors++;
          $display("FAIL rand_port%0d cyc=%0d addr=%0d: got %h/%b required %h/%b", p, n, a,
                   rs_data[p*XLEN +: XLEN], rs_busy[p], exp_data(a), exp_busy(a));
        end
      end
      checks++;
      if (hazard !== |({exp_busy(rs_addr[9:5]), exp_busy(rs_addr[4:0])} & rs_use)) begin
        errors++;
        $display("FAIL rand_hazard cyc=%0d: got %b use=%b", n, hazard, rs_use);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    rs_addr = 0;
    rst = 1;
    tick();
    tick();
    idle();
    test_reset();
    test_write_read();
    test_scoreboard();
    test_simultaneous();
    test_enable();
    test_bypass();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
